// File: rtl/pool_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pool_ctrl                                                     |
// | Desc     : Streams a 2N x 2N tile to a max-pool unit, stores N x N       |
// |            results. Optional macro POOL_CTRL_HISTORY_EN adds hist ports. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pool_ctrl #(
  parameter int N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  src_base_i,
  input  logic [7:0]  dst_base_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [15:0] rd_data_i,
  output logic        pool_load_o,
  output logic [15:0] pool_in_o,
  input  logic        pool_vld_i,
  input  logic [15:0] pool_res_i,
  input  logic [2:0]  pool_his_i,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        busy_o,
  output logic        done_o
`ifdef POOL_CTRL_HISTORY_EN
  ,
  output logic        hist_wr_en_o,
  output logic [2:0]  hist_wr_data_o
`endif
);

  localparam int NUM_RD = 4 * N * N;
  localparam int NUM_WR = N * N;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e      state_q;
  logic [7:0]  src_q;
  logic [7:0]  dst_q;
  logic [8:0]  k_q;
  logic [6:0]  m_q;
  logic        rd_en_q;
  logic [7:0]  rd_addr_q;
  logic        pool_load_q;
  logic        busy_q;
  logic        done_q;
  logic        wr_fire;

  // Results are written in the same cycle the pooling unit flags them valid.
  assign wr_fire = pool_vld_i && ((state_q == WAIT) || (state_q == STORE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= 8'd0;
      dst_q       <= 8'd0;
      k_q         <= 9'd0;
      m_q         <= 7'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 8'd0;
      pool_load_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pool_load_q <= rd_en_q;
      done_q      <= 1'b0;
      if ((state_q != IDLE) && abort_i) begin
        state_q     <= IDLE;
        rd_en_q     <= 1'b0;
        pool_load_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !abort_i) begin
              src_q     <= src_base_i;
              dst_q     <= dst_base_i;
              k_q       <= 9'd0;
              m_q       <= 7'd0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= src_base_i;
              busy_q    <= 1'b1;
              state_q   <= FETCH;
            end
          end
          FETCH: begin
            if (k_q == 9'(NUM_RD - 1)) begin
              rd_en_q <= 1'b0;
              state_q <= WAIT;
            end else begin
              k_q       <= k_q + 9'd1;
              rd_addr_q <= src_q + k_q[7:0] + 8'd1;
            end
          end
          WAIT, STORE: begin
            if (wr_fire) begin
              if (m_q == 7'(NUM_WR - 1)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                m_q     <= m_q + 7'd1;
                state_q <= STORE;
              end
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign pool_load_o = pool_load_q;
  assign pool_in_o   = pool_load_q ? rd_data_i : 16'd0;
  assign wr_en_o     = wr_fire;
  assign wr_addr_o   = wr_fire ? (dst_q + {1'b0, m_q}) : 8'd0;
  assign wr_data_o   = wr_fire ? pool_res_i : 16'd0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef POOL_CTRL_HISTORY_EN
  assign hist_wr_en_o   = wr_fire;
  assign hist_wr_data_o = wr_fire ? pool_his_i : 3'd0;
`else
  logic unused_his;
  assign unused_his = ^pool_his_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pool_ctrl                                                  |
// | Desc     : Scoreboard bench for pool_ctrl (N=3), directed job sequence.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pool_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  src_base_i;
  logic [7:0]  dst_base_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [15:0] rd_data_i;
  logic        pool_load_o;
  logic [15:0] pool_in_o;
  logic        pool_vld_i;
  logic [15:0] pool_res_i;
  logic [2:0]  pool_his_i;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
`ifdef POOL_CTRL_HISTORY_EN
  logic        hist_wr_en_o;
  logic [2:0]  hist_wr_data_o;
`endif

  pool_ctrl #(.N(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .src_base_i  (src_base_i),
    .dst_base_i  (dst_base_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .pool_load_o (pool_load_o),
    .pool_in_o   (pool_in_o),
    .pool_vld_i  (pool_vld_i),
    .pool_res_i  (pool_res_i),
    .pool_his_i  (pool_his_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef POOL_CTRL_HISTORY_EN
    ,
    .hist_wr_en_o   (hist_wr_en_o),
    .hist_wr_data_o (hist_wr_data_o)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    logic [2:0]  h;
  } wr_t;

  logic [7:0]  q_rd[$];
  logic [15:0] q_ld[$];
  wr_t         q_wr[$];
  int          total;
  int          passed;
  int          n_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  // Source memory: one-cycle read latency.
  always @(posedge clk) rd_data_i <= rd_en_o ? memf(rd_addr_o) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rd_en_o === 1'b1) begin
      if (q_rd.size() == 0) check("rd_unexpected", 32'(rd_en_o), 32'd0);
      else check("rd_addr", 32'(rd_addr_o), 32'(q_rd.pop_front()));
    end
    if (pool_load_o === 1'b1) begin
      if (q_ld.size() == 0) check("load_unexpected", 32'(pool_load_o), 32'd0);
      else check("pool_in", 32'(pool_in_o), 32'(q_ld.pop_front()));
    end
    if (wr_en_o === 1'b1) begin
      if (q_wr.size() == 0) check("wr_unexpected", 32'(wr_en_o), 32'd0);
      else begin
        wr_t e;
        e = q_wr.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e.a));
        check("wr_data", 32'(wr_data_o), 32'(e.d));
`ifdef POOL_CTRL_HISTORY_EN
        check("hist_en", 32'(hist_wr_en_o), 32'd1);
        check("hist_data", 32'(hist_wr_data_o), 32'(e.h));
`endif
      end
    end
    if (done_o === 1'b1) n_done++;
  end

  task automatic push_reads(input logic [7:0] src, input int nrd, input int nld);
    for (int k = 0; k < nrd; k++) q_rd.push_back(8'(src + 8'(k)));
    for (int k = 0; k < nld; k++) q_ld.push_back(memf(8'(src + 8'(k))));
  endtask

  // Returns at the first FETCH cycle, 1 time unit past the edge.
  task automatic start_job(input logic [7:0] src, input logic [7:0] dst);
    @(posedge clk); #1;
    start_i = 1'b1; src_base_i = src; dst_base_i = dst;
    @(posedge clk); #1;
    start_i = 1'b0; src_base_i = 8'h00; dst_base_i = 8'h00;
  endtask

  task automatic run_job(input logic [7:0] src, input logic [7:0] dst,
                         input bit toggle, input bit vld_in_done, input int done_exp);
    int  m;
    int  c;
    wr_t e;
    m = 0;
    c = 0;
    push_reads(src, 36, 36);
    start_job(src, dst);
    // Nonzero bases on the bus while busy must be ignored.
    start_i = 1'b1; src_base_i = 8'h55; dst_base_i = 8'h66;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    check("wait_rd_en", 32'(rd_en_o), 32'd0);
    check("wait_last_load", 32'(pool_load_o), 32'd1);
    while (m < 9) begin
      pool_vld_i = toggle ? ~c[0] : 1'b1;
      if (pool_vld_i) begin
        pool_res_i = toggle ? 16'(16'h0100 + m) : 16'(m + 1);
        pool_his_i = 3'(m % 4);
        e.a = 8'(dst + 8'(m)); e.d = pool_res_i; e.h = pool_his_i;
        q_wr.push_back(e);
        m++;
      end
      c++;
      @(posedge clk); #1;
    end
    pool_vld_i = vld_in_done;
    pool_res_i = 16'hBEEF;
    check("done_pulse", 32'(done_o), 32'd1);
    check("busy_in_done", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    pool_vld_i = 1'b0;
    check("done_cleared", 32'(done_o), 32'd0);
    check("busy_cleared", 32'(busy_o), 32'd0);
    check("done_count", 32'(n_done), 32'(done_exp));
    check("q_rd_empty", 32'(q_rd.size()), 32'd0);
    check("q_ld_empty", 32'(q_ld.size()), 32'd0);
    check("q_wr_empty", 32'(q_wr.size()), 32'd0);
  endtask

  initial begin
    wr_t e;
    total = 0; passed = 0; n_done = 0;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    src_base_i = 8'h00; dst_base_i = 8'h00;
    pool_vld_i = 1'b0; pool_res_i = 16'h0000; pool_his_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en_o), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_pool_load", 32'(pool_load_o), 32'd0);
    check("rst_pool_in", 32'(pool_in_o), 32'd0);
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst = 1'b0;

    run_job(8'h10, 8'h80, 1'b0, 1'b0, 1);
    run_job(8'hF0, 8'h40, 1'b1, 1'b1, 2);

    // Abort in the fifth FETCH cycle.
    push_reads(8'h20, 5, 4);
    start_job(8'h20, 8'h90);
    repeat (4) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_rd_en", 32'(rd_en_o), 32'd0);
    check("abort_load", 32'(pool_load_o), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done), 32'd2);
    check("abort_q_rd", 32'(q_rd.size()), 32'd0);
    check("abort_q_ld", 32'(q_ld.size()), 32'd0);

    // Abort and start together in IDLE: job refused.
    start_i = 1'b1; abort_i = 1'b1; src_base_i = 8'h30; dst_base_i = 8'h30;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_start_busy", 32'(busy_o), 32'd0);
    check("abort_start_rd_en", 32'(rd_en_o), 32'd0);

    run_job(8'h00, 8'hA0, 1'b0, 1'b0, 3);

    // Reset asserted alongside the third result write.
    push_reads(8'h44, 36, 36);
    start_job(8'h44, 8'hC0);
    repeat (36) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pool_vld_i = 1'b1;
      pool_res_i = 16'(16'h0700 + i);
      pool_his_i = 3'(i);
      e.a = 8'(8'hC0 + 8'(i)); e.d = pool_res_i; e.h = pool_his_i;
      q_wr.push_back(e);
      if (i == 2) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; pool_vld_i = 1'b0;
    check("rst_job_busy", 32'(busy_o), 32'd0);
    check("rst_job_done", 32'(done_o), 32'd0);
    check("rst_job_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_job_rd_en", 32'(rd_en_o), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_job_no_done", 32'(n_done), 32'd3);
    check("rst_job_q_wr", 32'(q_wr.size()), 32'd0);

    run_job(8'hFA, 8'hFC, 1'b0, 1'b0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter N, default 3, sets pooled output dimension; input tile is 2N x 2N; legal range 1..8.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-005 abort  input  1  cancels the running job.
REQ-006 src_base  input  8  feature-map base address, latched on accepted start.
REQ-007 dst_base  input  8  result base address, latched on accepted start.
REQ-008 rd_en  output  1  source-memory read strobe.
REQ-009 rd_addr  output  8  source-memory read address.
REQ-010 rd_data  input  16  source-memory data, valid exactly one cycle after rd_en.
REQ-011 pool_load  output  1  load strobe to pooling unit.
REQ-012 pool_in  output  16  sample to pooling unit.
REQ-013 pool_vld  input  1  pooling unit result-valid.
REQ-014 pool_res  input  16  pooled maximum.
REQ-015 pool_his  input  3  winning-position index (0..3).
REQ-016 wr_en  output  1  destination-memory write strobe.
REQ-017 wr_addr  output  8  destination-memory write address.
REQ-018 wr_data  output  16  destination-memory write data.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 done  output  1  one-cycle completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, WAIT, STORE, DONE.
REQ-022 IDLE: start=1 latches src_base/dst_base, clears counters, enters FETCH next cycle; start in any other state is ignored.
REQ-023 FETCH: rd_en=1 each cycle, rd_addr=src_base+k for k=0..4N*N-1 in row-major order, 8-bit wrap-around addition.
REQ-024 Each rd_data SHALL be forwarded as pool_in with pool_load=1 in the cycle after its rd_en; no bubbles; exactly 4N*N loads per job.
REQ-025 After the last rd_en, FSM enters WAIT; the final pool_load is issued in the first WAIT cycle.
REQ-026 WAIT: first cycle with pool_vld=1 enters STORE and that cycle's result is written.
REQ-027 STORE: each pool_vld=1 cycle writes wr_en=1, wr_addr=dst_base+m, wr_data=pool_res, m=0..N*N-1; pool_vld=0 cycles write nothing and hold m.
REQ-028 Write with m=N*N-1 SHALL move FSM to DONE; further pool_vld ignored.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; busy=0 from that IDLE cycle.
REQ-030 abort=1 in any non-IDLE state: next state IDLE, rd_en/pool_load/wr_en deasserted next cycle, done never asserted for that job.
REQ-031 abort and start in the same IDLE cycle: abort wins, job not accepted.
REQ-032 rd_en, pool_load, wr_en SHALL never assert in IDLE or DONE.

Reset
REQ-033 rst=1 at a clock edge forces IDLE, clears all counters and latched bases, mid-job included.
REQ-034 Reset values: rd_en=0, rd_addr=0, pool_load=0, pool_in=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.

Configuration
REQ-035 Macro POOL_CTRL_HISTORY_EN, when defined, adds output hist_wr_en (1) and hist_wr_data (3): hist_wr_en equals wr_en and hist_wr_data=pool_his, same cycle and address as wr_data.
REQ-036 Without POOL_CTRL_HISTORY_EN those ports and their logic SHALL not exist; pool_his is ignored; all other behaviour identical.

Verification
REQ-037 N=3, start with src_base=0x10, dst_base=0x80: rd_addr 0x10..0x33 over 36 consecutive cycles, 36 pool_load pulses each one cycle after matching rd_en.
REQ-038 Same job, pool_vld high 9 consecutive cycles with pool_res 1..9: writes to 0x80..0x88 with data 1..9, done pulse one cycle after the 9th write, busy low next cycle.
REQ-039 pool_vld toggled 1,0,1,0 in STORE: writes only on high cycles, addresses contiguous, done after the 9th write.
REQ-040 src_base=0xF0: rd_addr wraps 0xFF -> 0x00, 36 reads total.
REQ-041 abort at 5th FETCH cycle, and separately rst at 3rd STORE write: IDLE next cycle, no done, no further strobes; new start then runs a full clean job.
REQ-042 With POOL_CTRL_HISTORY_EN, pool_his 0,1,2,3 on successive writes: hist_wr_data 0,1,2,3 aligned to wr_en.
